// File: rtl/debug_unit_pkg.sv
// Shared constants and types for the debug unit: command bytes, the HALT word,
// FSM state encodings and the word/byte/address counts used by the dump.
package debug_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  CMD_RUN   = 8'h43;
  localparam logic [7:0]  CMD_STEP  = 8'h53;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Byte index of the last byte in a word, and last register/memory address.
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;
  localparam logic [4:0] LAST_ADDR     = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP       = 3'd3,
    ST_DUMP_ADDR  = 3'd4,
    ST_DUMP_LATCH = 3'd5,
    ST_DUMP_SEND  = 3'd6,
    ST_DUMP_WAIT  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SRC_PC  = 2'd0,
    SRC_REG = 2'd1,
    SRC_MEM = 2'd2
  } dump_src_t;

endpackage

// File: rtl/debug_unit_word_serializer.sv
// Splits a latched 32-bit word into bytes, MSB first; each send request
// emits one byte with a single-cycle tx_start pulse.
module word_serializer
  import debug_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              send,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  output logic              word_done
);

  logic [WORD_W-1:0] shift_r;
  logic [1:0]        cnt_r;
  logic              done_r;
  logic [BYTE_W-1:0] tx_data_r;
  logic              tx_start_r;

  // Word latch, byte shifter and registered transmit handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r    <= {WORD_W{1'b0}};
      cnt_r      <= 2'd0;
      done_r     <= 1'b0;
      tx_data_r  <= {BYTE_W{1'b0}};
      tx_start_r <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      if (load) begin
        shift_r <= word;
        cnt_r   <= 2'd0;
        done_r  <= 1'b0;
      end else if (send) begin
        tx_data_r  <= shift_r[WORD_W-1 -: BYTE_W];
        shift_r    <= {shift_r[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        tx_start_r <= 1'b1;
        cnt_r      <= cnt_r + 2'd1;
        done_r     <= (cnt_r == LAST_BYTE_IDX);
      end
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_start  = tx_start_r;
  assign word_done = done_r;

endmodule

// File: rtl/debug_unit.sv
// Debug controller: loads program words from a serial link, runs or steps the
// pipeline, then dumps PC, 32 registers and 32 memory words over the link.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int INST_SZ = 32,
  parameter int PC_SZ   = 32,
  parameter int REG_SZ  = 5,
  parameter int BYTE_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [INST_SZ-1:0] i_reg_data,
  input  logic [INST_SZ-1:0] i_mem_data,
  input  logic               i_halt,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_write,
  output logic               o_enable,
  output logic [REG_SZ-1:0]  o_debug_addr,
  output logic               o_busy
);

  state_t             state_r, state_s;
  dump_src_t          src_r, src_s;
  logic [1:0]         byte_cnt_r, byte_cnt_s;
  logic [INST_SZ-1:0] asm_r, asm_s;
  logic [INST_SZ-1:0] instr_r, instr_s;
  logic               write_r, write_s;
  logic               enable_r, enable_s;
  logic [REG_SZ-1:0]  addr_r, addr_s;
  logic               busy_r;
  logic               load_s, send_s;
  logic               word_done_s;
  logic [INST_SZ-1:0] dump_word_s;

  // Source selection for the word being latched into the serializer
  always_comb begin
    dump_word_s = i_pc;
    case (src_r)
      SRC_PC:  dump_word_s = i_pc;
      SRC_REG: dump_word_s = i_reg_data;
      SRC_MEM: dump_word_s = i_mem_data;
      default: dump_word_s = i_pc;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    src_s      = src_r;
    byte_cnt_s = byte_cnt_r;
    asm_s      = asm_r;
    instr_s    = instr_r;
    write_s    = 1'b0;
    enable_s   = 1'b0;
    addr_s     = addr_r;
    load_s     = 1'b0;
    send_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: state_s = ST_LOAD;
            CMD_RUN, CMD_STEP: begin
              if (i_halt) begin
                state_s = ST_DUMP_ADDR;
                src_s   = SRC_PC;
                addr_s  = 5'd0;
              end else begin
                state_s  = (i_rx_data == CMD_RUN) ? ST_RUN : ST_STEP;
                enable_s = 1'b1;
              end
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Leave one cycle after the HALT word has been written.
        if (write_r && (instr_r == HALT_WORD)) begin
          state_s = ST_IDLE;
        end else if (i_rx_done) begin
          asm_s      = {asm_r[INST_SZ-BYTE_SZ-1:0], i_rx_data};
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == LAST_BYTE_IDX) begin
            instr_s = {asm_r[INST_SZ-BYTE_SZ-1:0], i_rx_data};
            write_s = 1'b1;
          end else begin
            write_s = 1'b0;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_s = ST_DUMP_ADDR;
          src_s   = SRC_PC;
          addr_s  = 5'd0;
        end else begin
          enable_s = 1'b1;
        end
      end
      ST_STEP: begin
        state_s = ST_DUMP_ADDR;
        src_s   = SRC_PC;
        addr_s  = 5'd0;
      end
      ST_DUMP_ADDR:  state_s = ST_DUMP_LATCH;
      ST_DUMP_LATCH: begin
        load_s  = 1'b1;
        state_s = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        send_s  = 1'b1;
        state_s = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (i_tx_done) begin
          if (!word_done_s) begin
            state_s = ST_DUMP_SEND;
          end else begin
            // Address wraps 31 -> 0 on the register-to-memory switch.
            case (src_r)
              SRC_PC: begin
                src_s   = SRC_REG;
                addr_s  = 5'd0;
                state_s = ST_DUMP_ADDR;
              end
              SRC_REG: begin
                if (addr_r == LAST_ADDR) begin
                  src_s = SRC_MEM;
                end else begin
                  src_s = SRC_REG;
                end
                addr_s  = addr_r + 5'd1;
                state_s = ST_DUMP_ADDR;
              end
              SRC_MEM: begin
                addr_s  = addr_r + 5'd1;
                state_s = (addr_r == LAST_ADDR) ? ST_IDLE : ST_DUMP_ADDR;
              end
              default: state_s = ST_IDLE;
            endcase
          end
        end else begin
          state_s = ST_DUMP_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      src_r      <= SRC_PC;
      byte_cnt_r <= 2'd0;
      asm_r      <= {INST_SZ{1'b0}};
      instr_r    <= {INST_SZ{1'b0}};
      write_r    <= 1'b0;
      enable_r   <= 1'b0;
      addr_r     <= {REG_SZ{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      src_r      <= src_s;
      byte_cnt_r <= byte_cnt_s;
      asm_r      <= asm_s;
      instr_r    <= instr_s;
      write_r    <= write_s;
      enable_r   <= enable_s;
      addr_r     <= addr_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  word_serializer u_serializer (
    .clk       (i_clk),
    .reset     (i_reset),
    .load      (load_s),
    .word      (dump_word_s),
    .send      (send_s),
    .tx_data   (o_tx_data),
    .tx_start  (o_tx_start),
    .word_done (word_done_s)
  );

  assign o_instruction = instr_r;
  assign o_write       = write_r;
  assign o_enable      = enable_r;
  assign o_debug_addr  = addr_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: table-driven LOAD vectors plus directed
// STEP/RUN/dump/reset sequences checked against a byte-level dump model.
module tb_debug_unit;

  localparam int DUMP_BYTES = 260;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_done = 1'b0;
  logic        i_tx_done = 1'b0;
  logic [31:0] i_pc = 32'h0;
  logic [31:0] i_reg_data;
  logic [31:0] i_mem_data;
  logic        i_halt = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic [31:0] o_instruction;
  logic        o_write;
  logic        o_enable;
  logic [4:0]  o_debug_addr;
  logic        o_busy;

  debug_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_pc(i_pc), .i_reg_data(i_reg_data), .i_mem_data(i_mem_data),
    .i_halt(i_halt), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_instruction(o_instruction), .o_write(o_write), .o_enable(o_enable),
    .o_debug_addr(o_debug_addr), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Register file holds k, data memory holds 0x100+k.
  assign i_reg_data = {27'd0, o_debug_addr};
  assign i_mem_data = 32'h0000_0100 + {27'd0, o_debug_addr};

  int          n_cmp = 0;
  int          n_err = 0;
  int          en_cnt = 0;
  int          wr_cnt = 0;
  int          overlap_cnt = 0;
  int          tx_cd = 0;
  logic [31:0] wr_last = 32'h0;
  logic [7:0]  tx_q[$];

  // Output monitor
  always @(negedge i_clk) begin
    if (o_enable) en_cnt++;
    if (o_write) begin
      wr_cnt++;
      wr_last = o_instruction;
    end
    if (o_tx_start) tx_q.push_back(o_tx_data);
    if ((int'(o_enable) + int'(o_write) + int'(o_tx_start)) > 1) overlap_cnt++;
  end

  // Transmitter model: reports done three cycles after each start
  always @(negedge i_clk) begin
    i_tx_done = 1'b0;
    if (tx_cd > 0) begin
      tx_cd--;
      if (tx_cd == 0) i_tx_done = 1'b1;
    end
    if (o_tx_start) tx_cd = 3;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (o_busy === 1'b1 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: busy still high after %0d cycles, expected low", tag, budget);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pc);
    int w = k / 4;
    logic [31:0] word;
    if (w == 0) word = pc;
    else if (w <= 32) word = 32'(w - 1);
    else word = 32'h0000_0100 + 32'(w - 33);
    return word[31 - 8 * (k % 4) -: 8];
  endfunction

  task automatic check_dump(input string tag, input int base, input logic [31:0] pc);
    int bad = 0;
    check({tag, " byte count"}, 32'(tx_q.size() - base), 32'(DUMP_BYTES));
    for (int k = 0; k < DUMP_BYTES; k++) begin
      if (base + k < tx_q.size()) begin
        if (tx_q[base + k] !== exp_byte(k, pc)) bad++;
      end
    end
    check({tag, " bad bytes"}, 32'(bad), 32'd0);
    check({tag, " addr after dump"}, {27'd0, o_debug_addr}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
    logic        exp_busy;
  } load_vec_t;

  load_vec_t lv[5];
  logic [7:0] idle_bytes[3];
  logic [7:0] step_head[12];
  logic [7:0] run_tail[4];

  initial begin
    int en_base, wr_base, tx_base;

    lv[0] = '{8'h20, 8'h01, 8'h00, 8'h05, 32'h2001_0005, 1'b1};
    lv[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEAD_BEEF, 1'b1};
    lv[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b1};
    lv[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 32'hFFFF_FFFE, 1'b1};
    lv[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 1'b0};
    idle_bytes = '{8'h00, 8'h41, 8'h6C};
    step_head  = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h01};
    run_tail   = '{8'h00, 8'h00, 8'h01, 8'h1F};

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst tx_start", {31'd0, o_tx_start}, 32'd0);
    check("rst write", {31'd0, o_write}, 32'd0);
    check("rst enable", {31'd0, o_enable}, 32'd0);
    check("rst busy", {31'd0, o_busy}, 32'd0);
    check("rst tx_data", {24'd0, o_tx_data}, 32'd0);
    check("rst instruction", o_instruction, 32'd0);
    check("rst debug_addr", {27'd0, o_debug_addr}, 32'd0);
    i_reset = 1'b0;

    // Unknown bytes in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      send_byte(idle_bytes[i]);
      @(negedge i_clk);
      check($sformatf("idle ignore 0x%0h", idle_bytes[i]), {31'd0, o_busy}, 32'd0);
    end

    // Program load, table driven, ending with the HALT word
    send_byte(8'h4C);
    for (int i = 0; i < 5; i++) begin
      wr_base = wr_cnt;
      send_byte(lv[i].b0);
      send_byte(lv[i].b1);
      send_byte(lv[i].b2);
      send_byte(lv[i].b3);
      repeat (2) @(negedge i_clk);
      check($sformatf("load%0d writes", i), 32'(wr_cnt - wr_base), 32'd1);
      check($sformatf("load%0d word", i), wr_last, lv[i].exp_word);
      check($sformatf("load%0d busy", i), {31'd0, o_busy}, {31'd0, lv[i].exp_busy});
    end

    // Single step with halt low
    i_pc = 32'h0000_0004;
    en_base = en_cnt;
    tx_base = tx_q.size();
    send_byte(8'h53);
    wait_idle("step", 5000);
    check("step enable cycles", 32'(en_cnt - en_base), 32'd1);
    for (int k = 0; k < 12; k++)
      if (tx_base + k < tx_q.size())
        check($sformatf("step head byte %0d", k), {24'd0, tx_q[tx_base + k]}, {24'd0, step_head[k]});
    check_dump("step", tx_base, 32'h0000_0004);

    // Continuous run, halt sampled ten cycles after the command
    i_pc = 32'h0000_0040;
    en_base = en_cnt;
    tx_base = tx_q.size();
    send_byte(8'h43);
    repeat (9) @(negedge i_clk);
    i_halt = 1'b1;
    wait_idle("run", 5000);
    check("run enable cycles", 32'(en_cnt - en_base), 32'd10);
    for (int k = 0; k < 4; k++)
      if (tx_base + DUMP_BYTES - 4 + k < tx_q.size())
        check($sformatf("run tail byte %0d", k), {24'd0, tx_q[tx_base + DUMP_BYTES - 4 + k]},
              {24'd0, run_tail[k]});
    check_dump("run", tx_base, 32'h0000_0040);

    // Step with halt already set: no enable, dump only
    en_base = en_cnt;
    tx_base = tx_q.size();
    send_byte(8'h53);
    @(negedge i_clk);
    check("halted step busy", {31'd0, o_busy}, 32'd1);
    wait_idle("halted step", 5000);
    check("halted step enable cycles", 32'(en_cnt - en_base), 32'd0);
    check_dump("halted step", tx_base, 32'h0000_0040);
    i_halt = 1'b0;

    // Reset in the middle of a LOAD word
    wr_base = wr_cnt;
    send_byte(8'h4C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("reset mid-load busy", {31'd0, o_busy}, 32'd0);
    check("reset mid-load no write", 32'(wr_cnt - wr_base), 32'd0);
    send_byte(8'h4C);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (2) @(negedge i_clk);
    check("post-reset word", wr_last, 32'h1122_3344);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    repeat (2) @(negedge i_clk);
    check("post-reset writes", 32'(wr_cnt - wr_base), 32'd2);
    check("post-reset load exit", {31'd0, o_busy}, 32'd0);

    // Step command byte arriving mid-dump is dropped
    i_pc = 32'h0000_0008;
    en_base = en_cnt;
    tx_base = tx_q.size();
    send_byte(8'h53);
    repeat (50) @(negedge i_clk);
    send_byte(8'h53);
    wait_idle("dump rx drop", 5000);
    check("dump rx drop enable", 32'(en_cnt - en_base), 32'd1);
    check_dump("dump rx drop", tx_base, 32'h0000_0008);
    repeat (100) @(negedge i_clk);
    check("no extra dump", 32'(tx_q.size() - tx_base), 32'(DUMP_BYTES));
    check("idle after dump", {31'd0, o_busy}, 32'd0);

    check("strobe overlap cycles", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameters SHALL be: INST_SZ 32 (instruction/data word width); PC_SZ 32 (program counter width); REG_SZ 5 (debug address width); BYTE_SZ 8 (serial byte width).
REQ-002 Port i_clk SHALL be an input, 1 bit: the single clock.
REQ-003 Port i_reset SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-004 Port i_rx_data SHALL be an input, BYTE_SZ bits: received byte, valid when i_rx_done=1.
REQ-005 Port i_rx_done SHALL be an input, 1 bit: one-cycle pulse marking a received byte.
REQ-006 Port i_tx_done SHALL be an input, 1 bit: one-cycle pulse when the transmitter has finished the current byte.
REQ-007 Port i_pc SHALL be an input, PC_SZ bits: pipeline PC.
REQ-008 Port i_reg_data SHALL be an input, INST_SZ bits: register file word at o_debug_addr.
REQ-009 Port i_mem_data SHALL be an input, INST_SZ bits: data memory word at o_debug_addr.
REQ-010 Port i_halt SHALL be an input, 1 bit: pipeline has retired HALT.
REQ-011 Port o_tx_data SHALL be an output, BYTE_SZ bits: byte to transmit.
REQ-012 Port o_tx_start SHALL be an output, 1 bit: one-cycle pulse starting transmission of o_tx_data.
REQ-013 Port o_instruction SHALL be an output, INST_SZ bits: instruction word to store in instruction memory.
REQ-014 Port o_write SHALL be an output, 1 bit: one-cycle instruction-memory write strobe.
REQ-015 Port o_enable SHALL be an output, 1 bit: pipeline execution enable.
REQ-016 Port o_debug_addr SHALL be an output, REG_SZ bits: register/memory dump address.
REQ-017 Port o_busy SHALL be an output, 1 bit: high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, LOAD, RUN, STEP, DUMP_ADDR, DUMP_LATCH, DUMP_SEND and DUMP_WAIT.
REQ-019 In IDLE, a received byte SHALL be decoded as follows: 0x4C ('L') -> LOAD; 0x43 ('C') -> RUN; 0x53 ('S') -> STEP; any other byte is ignored.
REQ-020 In LOAD, bytes SHALL assemble into a word MSB first with a 2-bit byte counter that wraps from 3 to 0; on the 4th byte, o_instruction is set to the word and o_write pulses high for exactly one cycle on the following cycle.
REQ-021 LOAD SHALL return to IDLE on the cycle after writing a word equal to 0xFFFFFFFF (HALT encoding); that word is itself written.
REQ-022 RUN SHALL hold o_enable=1 each cycle until the cycle i_halt=1 is sampled, deassert o_enable in that same cycle, then enter DUMP_ADDR.
REQ-023 STEP SHALL assert o_enable for exactly one cycle, then enter DUMP_ADDR.
REQ-024 If i_halt=1 when 'C' or 'S' is decoded, o_enable SHALL stay 0 and the FSM SHALL go directly to DUMP_ADDR.
REQ-025 The dump sequence SHALL be: PC word; register words for addresses 0..31; memory words for addresses 0..31; 65 words (260 bytes) total, each sent MSB first.
REQ-026 DUMP_ADDR SHALL drive o_debug_addr, and DUMP_LATCH SHALL capture the selected source one cycle later (single settle cycle).
REQ-027 DUMP_SEND SHALL pulse o_tx_start for one cycle with o_tx_data valid; DUMP_WAIT SHALL hold until i_tx_done, then send the next byte or advance the word.
REQ-028 The 5-bit address counter SHALL wrap from 31 to 0 when switching from registers to memory; after memory word 31 the FSM SHALL return to IDLE.
REQ-029 i_rx_done pulses SHALL be dropped in RUN, STEP and all DUMP states; i_tx_done SHALL be ignored outside DUMP_WAIT.
REQ-030 o_write, o_enable and o_tx_start SHALL never be high in the same cycle.

Reset
REQ-031 When i_reset=1 at a clock edge, the FSM SHALL enter IDLE; o_tx_start=0, o_write=0, o_enable=0, o_busy=0, o_tx_data=0, o_instruction=0, o_debug_addr=0; all counters and shift registers are cleared.
REQ-032 Reset mid-LOAD or mid-DUMP SHALL discard any partial word; no write or tx pulse occurs on the reset cycle.

Structure
REQ-033 Command codes, the HALT word, state encodings and word/byte counts SHALL live in the shared debug constants include file.
REQ-034 The 32-bit-to-byte MSB-first serializer with tx handshake SHALL be a sub-module named word_serializer; the FSM stays in debug_unit.

Verification
REQ-035 Send 'L', 0x20,0x01,0x00,0x05, 0xFF,0xFF,0xFF,0xFF -> two single-cycle o_write pulses with 0x20010005 then 0xFFFFFFFF; o_busy=0 afterwards.
REQ-036 Send 'S' with i_halt=0, PC=0x00000004, reg[k]=k, mem[k]=0x100+k -> one o_enable cycle; tx bytes begin 00 00 00 04, 00 00 00 00, 00 00 00 01; 260 tx_start pulses in total.
REQ-037 Send 'C', raise i_halt 10 cycles later -> o_enable high exactly 10 cycles, then a 260-byte dump ending 00 00 01 1F.
REQ-038 Send 'S' with i_halt=1 already set -> o_enable never asserts; dump starts.
REQ-039 Assert i_reset after 2 bytes of a LOAD word, then send 'L' plus 4 bytes -> the word is built from only the post-reset bytes.
REQ-040 Send byte 0x53 during a dump -> it is ignored, and the dump byte count is unchanged at 260.
